// File: rtl/com_bus_mem_responder.sv
// Memory-side responder for the shared instruction-cache fill bus: arbitrates, waits, returns a word.
// `define ROUND_ROBIN_ARB_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module com_bus_mem_responder #(
    parameter int ADDRESSSIZE    = 32,
    parameter int NUM_PROC       = 4,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int MEM_LATENCY    = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_PROC-1:0]       Com_Bus_Req_proc,
    output logic [NUM_PROC-1:0]       Com_Bus_Gnt_proc,
    input  logic [ADDRESSSIZE-1:0]    Address_Com,
    inout  wire  [ADDRESSSIZE-1:0]    Data_Bus_Com,
    inout  wire                       Data_in_Bus,
    input  logic                      Mem_Wr,
    input  logic [MEM_DEPTH_LOG2-1:0] Mem_Wr_Addr,
    input  logic [ADDRESSSIZE-1:0]    Mem_Wr_Data
);
    localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, WAIT, DRIVE, RELEASE} state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          winner_q;
    logic [3:0]                count_q;
    logic [MEM_DEPTH_LOG2-1:0] index_q;
    logic [ADDRESSSIZE-1:0]    data_q;
    logic [ADDRESSSIZE-1:0]    mem [2**MEM_DEPTH_LOG2];

    logic             any_req;
    logic             granted_req;
    logic [IDX_W-1:0] pick;
    logic             unused_addr_hi;

    assign any_req        = |Com_Bus_Req_proc;
    assign granted_req    = Com_Bus_Req_proc[winner_q];
    assign unused_addr_hi = ^Address_Com[ADDRESSSIZE-1:MEM_DEPTH_LOG2];

`ifdef ROUND_ROBIN_ARB_EN
    logic [IDX_W-1:0] ptr_q;
    logic             release_evt;

    // Scan from the highest offset down so the nearest requester at/after the pointer wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick = ptr_q;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (Com_Bus_Req_proc[(int'(ptr_q) + i) % NUM_PROC])
                pick = IDX_W'((int'(ptr_q) + i) % NUM_PROC);
        end
    end

    // The pointer moves past the winner whenever its transaction ends, completed or aborted.
    assign release_evt = (state_q == GRANT || state_q == WAIT || state_q == RELEASE) && !granted_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr_q <= '0;
        else if (release_evt)
            ptr_q <= (winner_q == IDX_W'(NUM_PROC - 1)) ? '0 : winner_q + IDX_W'(1);
    end
`else
    always_comb begin
        pick = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (Com_Bus_Req_proc[i])
                pick = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            Com_Bus_Gnt_proc <= '0;
            winner_q         <= '0;
            count_q          <= '0;
            index_q          <= '0;
            data_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        winner_q         <= pick;
                        Com_Bus_Gnt_proc <= NUM_PROC'(1) << pick;
                        state_q          <= GRANT;
                    end
                end
                GRANT: begin
                    if (!granted_req) begin
                        Com_Bus_Gnt_proc <= '0;
                        state_q          <= IDLE;
                    end else begin
                        index_q <= Address_Com[MEM_DEPTH_LOG2-1:0];
                        count_q <= 4'(MEM_LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!granted_req) begin
                        Com_Bus_Gnt_proc <= '0;
                        state_q          <= IDLE;
                    end else if (count_q == 4'd0) begin
                        data_q  <= mem[index_q];
                        state_q <= DRIVE;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                DRIVE: state_q <= RELEASE;
                RELEASE: begin
                    if (!granted_req) begin
                        Com_Bus_Gnt_proc <= '0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the backing store is deliberately not reset; contents survive reset and are preloaded.
    always_ff @(posedge clk) begin
        if (Mem_Wr)
            mem[Mem_Wr_Addr] <= Mem_Wr_Data;
    end

    assign Data_Bus_Com = (state_q == DRIVE) ? data_q : 'z;
    assign Data_in_Bus  = (state_q == DRIVE)   ? 1'b1 :
                          (state_q == RELEASE) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_com_bus_mem_responder.sv
// Directed bench for com_bus_mem_responder with a fill-data scoreboard checked on every strobe.
module tb_com_bus_mem_responder;
    localparam int AW  = 32;
    localparam int NP  = 4;
    localparam int DL  = 10;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] Com_Bus_Req_proc = '0;
    logic [NP-1:0] Com_Bus_Gnt_proc;
    logic [AW-1:0] Address_Com = '0;
    wire  [AW-1:0] Data_Bus_Com;
    wire           Data_in_Bus;
    logic          Mem_Wr = 1'b0;
    logic [DL-1:0] Mem_Wr_Addr = '0;
    logic [AW-1:0] Mem_Wr_Data = '0;

    int            total = 0;
    int            bad = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_word;
    int            exp_u;
`ifdef ROUND_ROBIN_ARB_EN
    int            ptr_m;
`endif

    always #5 clk = ~clk;

    com_bus_mem_responder #(
        .ADDRESSSIZE(AW), .NUM_PROC(NP), .MEM_DEPTH_LOG2(DL), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .Com_Bus_Req_proc(Com_Bus_Req_proc), .Com_Bus_Gnt_proc(Com_Bus_Gnt_proc),
        .Address_Com(Address_Com), .Data_Bus_Com(Data_Bus_Com), .Data_in_Bus(Data_in_Bus),
        .Mem_Wr(Mem_Wr), .Mem_Wr_Addr(Mem_Wr_Addr), .Mem_Wr_Data(Mem_Wr_Data)
    );

    // A released line reads as Z in four-state simulators and as 0 in two-state ones.
    function automatic logic [AW-1:0] norm(input logic [AW-1:0] v);
        for (int i = 0; i < AW; i++)
            if (v[i] === 1'bz) v[i] = 1'b0;
        return v;
    endfunction

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_released(input string tag, input logic [AW-1:0] obs);
        check(tag, norm(obs), '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [DL-1:0] a, input logic [AW-1:0] d);
        Mem_Wr = 1'b1; Mem_Wr_Addr = a; Mem_Wr_Data = d;
        tick();
        Mem_Wr = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_gnt", AW'(Com_Bus_Gnt_proc), '0);
        check_released("rst_data", Data_Bus_Com);
        check_released("rst_strobe", AW'(Data_in_Bus));
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Called one cycle after the grant edge; walks the transaction through to IDLE.
    task automatic serve(input int u, input logic [AW-1:0] addr, input logic [AW-1:0] exp,
                         input bit wr, input logic [AW-1:0] wdata);
        check("gnt_winner", AW'(Com_Bus_Gnt_proc), AW'(1) << u);
        Address_Com = addr;
        exp_q.push_back(exp);
        tick();
        Address_Com = '0;
        if (wr) begin
            Mem_Wr = 1'b1; Mem_Wr_Addr = addr[DL-1:0]; Mem_Wr_Data = wdata;
        end
        tick();
        Mem_Wr = 1'b0;
        repeat (LAT - 2) tick();
        check_released("strobe_before_drive", AW'(Data_in_Bus));
        tick();
        check("strobe_drive", AW'(Data_in_Bus), AW'(1));
        tick();
        check("strobe_release", AW'(Data_in_Bus), '0);
        check("gnt_held_release", AW'(Com_Bus_Gnt_proc), AW'(1) << u);
        check_released("data_release", Data_Bus_Com);
        Com_Bus_Req_proc[u] = 1'b0;
        tick();
        check("gnt_dropped", AW'(Com_Bus_Gnt_proc), '0);
        check_released("strobe_idle", AW'(Data_in_Bus));
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            assert ($onehot0(Com_Bus_Gnt_proc)) else begin
                bad++;
                $error("FAIL gnt_onehot observed=%b expected=onehot0", Com_Bus_Gnt_proc);
            end
            if (Data_in_Bus === 1'b1) begin
                total++;
                assert (Com_Bus_Gnt_proc != '0) else begin
                    bad++;
                    $error("FAIL drive_without_gnt observed=%b expected=nonzero", Com_Bus_Gnt_proc);
                end
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_strobe observed=%h expected=no_strobe", Data_Bus_Com);
                end
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("fill_data", Data_Bus_Com, exp_word);
                end
            end
        end
    end

    initial begin
        apply_reset();
        mem_write(10'd5, 32'hDEAD_BEEF);
        mem_write(10'd7, 32'hCAFE_0007);
        for (int u = 0; u < NP; u++)
            mem_write(10'(16 + u), 32'hA5A5_0000 + u);

        // Single read: grant next cycle, data LAT+1 cycles after first grant.
        Com_Bus_Req_proc[0] = 1'b1;
        tick();
        serve(0, 32'd5, 32'hDEAD_BEEF, 1'b0, '0);

        // All four requesting; each re-requests after its data.
        apply_reset();
`ifdef ROUND_ROBIN_ARB_EN
        ptr_m = 0;
`endif
        Com_Bus_Req_proc = '1;
        for (int k = 0; k < 5; k++) begin
            tick();
`ifdef ROUND_ROBIN_ARB_EN
            exp_u = ptr_m;
            ptr_m = (ptr_m + 1) % NP;
`else
            exp_u = 0;
`endif
            serve(exp_u, 32'(16 + exp_u), 32'hA5A5_0000 + exp_u, 1'b0, '0);
            Com_Bus_Req_proc[exp_u] = 1'b1;
        end
        Com_Bus_Req_proc = '0;
        tick();

        // Upper address bits are ignored.
        Com_Bus_Req_proc[1] = 1'b1;
        tick();
        serve(1, 32'hFFFF_F007, 32'hCAFE_0007, 1'b0, '0);

        // Unit2 abandons during WAIT; unit3 follows after one idle cycle.
        apply_reset();
        Com_Bus_Req_proc = 4'b1100;
        tick();
        check("abort_gnt2", AW'(Com_Bus_Gnt_proc), AW'(4'b0100));
        Address_Com = 32'(18);
        tick();
        Com_Bus_Req_proc[2] = 1'b0;
        tick();
        check("abort_gnt_clear", AW'(Com_Bus_Gnt_proc), '0);
        check_released("abort_no_strobe", AW'(Data_in_Bus));
        tick();
        serve(3, 32'(19), 32'hA5A5_0003, 1'b0, '0);

        // Reset pulse in the middle of WAIT.
        Com_Bus_Req_proc[0] = 1'b1;
        tick();
        Address_Com = 32'd5;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_gnt", AW'(Com_Bus_Gnt_proc), '0);
        check_released("midrst_data", Data_Bus_Com);
        check_released("midrst_strobe", AW'(Data_in_Bus));
        Com_Bus_Req_proc = '0;
        tick();
        reset_n = 1'b1;
        repeat (LAT + 2) tick();
        check("postrst_gnt", AW'(Com_Bus_Gnt_proc), '0);
        Com_Bus_Req_proc[0] = 1'b1;
        tick();
        serve(0, 32'd5, 32'hDEAD_BEEF, 1'b0, '0);

        // Backdoor write to the in-flight index during WAIT is returned.
        Com_Bus_Req_proc[0] = 1'b1;
        tick();
        serve(0, 32'd5, 32'h1234_5678, 1'b1, 32'h1234_5678);

        tick();
        check("scoreboard_drained", AW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/com_bus_mem_responder.md
Name: com_bus_mem_responder

Overview:
- Memory-side end of the common bus used by the instruction-cache wrappers.
- Arbitrates bus requests from NUM_PROC cache units and grants one requester at a time.
- Samples the granted unit's miss address, waits a fixed memory latency, then drives the fill word on Data_Bus_Com with Data_in_Bus asserted.
- Holds a word-addressed backing store with a backdoor load port for bench preloading.

Parameters:
ADDRESSSIZE, 32, address/data word width (matches the `ADDRESSSIZE define)
NUM_PROC, 4, number of requesting cache units
MEM_DEPTH_LOG2, 10, backing store depth = 2**MEM_DEPTH_LOG2 words
MEM_LATENCY, 3, cycles from address sample to data drive (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
Com_Bus_Req_proc  input  NUM_PROC  per-unit bus request, level, held until data received
Com_Bus_Gnt_proc  output  NUM_PROC  per-unit grant, one-hot or zero
Address_Com  input  ADDRESSSIZE  word address driven by the granted unit
Data_Bus_Com  inout  ADDRESSSIZE  fill data; driven only in DRIVE, else high-Z
Data_in_Bus  inout  1  data-valid strobe; driven 1 in DRIVE, 0 in RELEASE, high-Z otherwise
Mem_Wr  input  1  backdoor write enable
Mem_Wr_Addr  input  MEM_DEPTH_LOG2  backdoor write index
Mem_Wr_Data  input  ADDRESSSIZE  backdoor write data

Behaviour:
- Reset (async, reset_n=0): state=IDLE, Com_Bus_Gnt_proc=0, Data_Bus_Com=Z, Data_in_Bus=Z, latency counter=0, round-robin pointer=0. Memory contents are not reset.
- Reset asserted mid-transaction aborts immediately. No stale data or grant appears after reset release.
- IDLE: if any Req is high, pick a winner by the arbitration rule, set its Gnt next cycle, go to GRANT. Otherwise remain.
- GRANT (1 cycle): sample Address_Com[MEM_DEPTH_LOG2-1:0] as the index; upper bits are ignored. Load counter=MEM_LATENCY-1, go to WAIT.
- WAIT: decrement counter each cycle. At 0, read mem[index] into the output register and go to DRIVE.
- Latency: the data-valid cycle is exactly MEM_LATENCY+1 cycles after the first Gnt-high cycle.
- DRIVE (1 cycle): drive Data_Bus_Com=data and Data_in_Bus=1. Go to RELEASE.
- RELEASE: Data_Bus_Com=Z, Data_in_Bus driven 0. Gnt stays high until the granted Req goes low.
  - On the cycle Req is observed low: deassert Gnt, advance the round-robin pointer to winner+1 (mod NUM_PROC), go to IDLE.
  - Minimum bus turnaround is one IDLE cycle between grants.
- Early Req drop: if the granted Req drops during GRANT or WAIT, abort. Go to IDLE next cycle with Gnt=0, no DRIVE, pointer still advanced.
- Non-granted Req changes never affect the current transaction.
- Backdoor write: mem[Mem_Wr_Addr] <= Mem_Wr_Data on clk, in any state.
  - A write to the in-flight index before the WAIT-to-DRIVE read is returned.
  - A write in the same cycle as that read returns the old data (read-before-write).
- Gnt is never multi-hot. Data_Bus_Com is never driven while Gnt=0.

Optional Feature:
ROUND_ROBIN_ARB_EN
- Defined: the winner is the first requester at or after the round-robin pointer, wrapping NUM_PROC-1 to 0.
- Undefined: fixed priority, lowest index wins, and the pointer is unused (may be optimised away).
- All other timing is identical in both builds.

Test Plan:
- Preload mem[5]=32'hDEAD_BEEF. Unit0 Req with Address_Com=5 -> Gnt[0] next cycle; data 32'hDEAD_BEEF with Data_in_Bus=1 exactly 4 cycles after first Gnt (MEM_LATENCY=3); Gnt[0] drops the cycle after Req[0] drops.
- Req[0..3] all high, each dropping after its data, ROUND_ROBIN_ARB_EN defined -> grant order 0,1,2,3,0. Without the macro -> 0,0,... while Req[0] is reasserted; unit3 is starved.
- Address_Com=32'hFFFF_F007 with MEM_DEPTH_LOG2=10 -> returns mem[10'h007].
- Unit2 drops Req during WAIT -> no Data_in_Bus pulse; Gnt[2]=0 next cycle; pending Req[3] granted after one IDLE cycle.
- reset_n pulsed low during WAIT -> all Gnt=0, buses high-Z immediately; a new request after release completes normally.
- Backdoor write mem[5]=32'h1234_5678 during WAIT of a read of index 5 (before the final count) -> 32'h1234_5678 is returned.
